// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - key code valid/ready link from the keypad scanner to its consumer
interface keypad_scan_ctrl_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
// and a one-entry key buffer with sticky overrun.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                row,
   output logic [3:0]                col,
   output logic                      key_down,
   output logic                      overrun,
   keypad_scan_ctrl_if.master        kif
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

   state_t        state, state_nx;
   logic [3:0]    row_m, row_s;
   logic [CW-1:0] cnt, cnt_nx;
   logic [DW-1:0] db, db_nx;
   logic [3:0]    col_nx;
   logic [1:0]    col_idx, col_idx_nx;
   logic [1:0]    row_idx, row_idx_nx;
   logic          commit;
   logic          hit;

   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

   function automatic logic [1:0] col_enc(input logic [3:0] c);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (c[i]) idx = 2'(i);
      return idx;
   endfunction

   // lowest set row wins when several keys in the column are down
   function automatic logic [1:0] low_idx(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (r[i]) idx = 2'(i);
      return idx;
   endfunction

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      db_nx      = db;
      col_nx     = col;
      col_idx_nx = col_idx;
      row_idx_nx = row_idx;
      commit     = 1'b0;
      hit        = row_s[row_idx];
      case (state)
         SCAN: begin
            if (cnt == CNT_LAST) begin
               if (row_s == 4'b0000) begin
                  col_nx = rotl(col);
                  cnt_nx = '0;
               end else begin
                  col_idx_nx = col_enc(col);
                  row_idx_nx = low_idx(row_s);
                  db_nx      = '0;
                  state_nx   = DEBOUNCE;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (hit) begin
               if (db == DB_LAST) begin
                  commit   = 1'b1;
                  db_nx    = '0;
                  state_nx = HOLD;
               end else begin
                  db_nx = db + 1'b1;
               end
            end else begin
               col_nx   = rotl(col);
               cnt_nx   = '0;
               state_nx = SCAN;
            end
         end
         HOLD: begin
            // a single bounce back to pressed restarts the release count
            if (!hit) begin
               if (db == DB_LAST) begin
                  col_nx   = rotl(col);
                  cnt_nx   = '0;
                  db_nx    = '0;
                  state_nx = SCAN;
               end else begin
                  db_nx = db + 1'b1;
               end
            end else begin
               db_nx = '0;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_m         <= 4'b0000;
         row_s         <= 4'b0000;
         state         <= SCAN;
         cnt           <= '0;
         db            <= '0;
         col           <= 4'b0001;
         col_idx       <= 2'd0;
         row_idx       <= 2'd0;
         key_down      <= 1'b0;
         overrun       <= 1'b0;
         kif.key_code  <= 4'd0;
         kif.key_valid <= 1'b0;
      end else begin
         row_m    <= row;
         row_s    <= row_m;
         state    <= state_nx;
         cnt      <= cnt_nx;
         db       <= db_nx;
         col      <= col_nx;
         col_idx  <= col_idx_nx;
         row_idx  <= row_idx_nx;
         key_down <= (state_nx == HOLD);
         // a consumer taking the old key in the commit cycle frees the slot
         if (commit) begin
            if (!kif.key_valid || kif.key_ready) begin
               kif.key_code  <= {row_idx, col_idx};
               kif.key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (kif.key_valid && kif.key_ready) begin
            kif.key_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - bench for keypad_scan_ctrl: keypad model, reference
// scanner model and directed plus randomized scenarios.
module tb_keypad_scan_ctrl;
   localparam int SD = 4;
   localparam int DB = 3;
   localparam int PH_SCAN = 0, PH_DB = 1, PH_HOLD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row = 4'b0000;
   logic [3:0] col;
   logic       key_down;
   logic       overrun;

   keypad_scan_ctrl_if kif ();

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .col      (col),
      .key_down (key_down),
      .overrun  (overrun),
      .kif      (kif)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] pressed = 16'h0000;
   bit          raw_en = 1'b0;
   logic [3:0]  raw_row = 4'b0000;
   int          valid_seen = 0;
   int          last_code = -1;

   int         m_phase, m_col, m_dwell, m_db, m_ridx, m_cidx, m_code;
   logic [3:0] m_s1, m_s2;
   bit         m_valid, m_over, m_down;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] kp_rows(input logic [15:0] p, input logic [3:0] c);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = |(p[i*4 +: 4] & c);
      return r;
   endfunction

   task automatic model_reset();
      m_phase = PH_SCAN; m_col = 0; m_dwell = 0; m_db = 0;
      m_ridx = 0; m_cidx = 0; m_code = 0;
      m_s1 = 4'b0000; m_s2 = 4'b0000;
      m_valid = 1'b0; m_over = 1'b0; m_down = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r_in, input logic rdy);
      logic [3:0] rs;
      bit commit;
      bit hit;
      rs = m_s2;
      commit = 1'b0;
      hit = rs[m_ridx];
      if (m_phase == PH_SCAN) begin
         if (m_dwell == SD - 1) begin
            if (rs == 4'b0000) begin
               m_col = (m_col + 1) % 4; m_dwell = 0;
            end else begin
               m_cidx = m_col;
               for (int i = 3; i >= 0; i--) if (rs[i]) m_ridx = i;
               m_db = 0; m_phase = PH_DB;
            end
         end else m_dwell++;
      end else if (m_phase == PH_DB) begin
         if (!hit) begin
            m_phase = PH_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
         end else if (m_db == DB - 1) begin
            commit = 1'b1; m_phase = PH_HOLD; m_db = 0;
         end else m_db++;
      end else begin
         if (hit) m_db = 0;
         else if (m_db == DB - 1) begin
            m_phase = PH_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0; m_db = 0;
         end else m_db++;
      end
      if (commit) begin
         if (!m_valid || rdy) begin m_code = m_ridx * 4 + m_cidx; m_valid = 1'b1; end
         else m_over = 1'b1;
      end else if (m_valid && rdy) m_valid = 1'b0;
      m_down = (m_phase == PH_HOLD);
      m_s2 = m_s1;
      m_s1 = r_in;
   endtask

   task automatic check_all();
      logic [3:0] ec;
      ec = 4'b0001 << m_col;
      check("col", col, ec);
      check("key_code", kif.key_code, m_code);
      check("key_valid", kif.key_valid, m_valid);
      check("key_down", key_down, m_down);
      check("overrun", overrun, m_over);
      if (kif.key_valid === 1'b1) begin
         valid_seen++;
         last_code = int'(kif.key_code);
      end
   endtask

   task automatic cycle();
      row = raw_en ? raw_row : kp_rows(pressed, col);
      @(posedge clk);
      if (rst) model_reset();
      else model_step(row, kif.key_ready);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_col"}, col, 4'b0001);
      check({tag, "_code"}, kif.key_code, 4'd0);
      check({tag, "_valid"}, kif.key_valid, 1'b0);
      check({tag, "_down"}, key_down, 1'b0);
      check({tag, "_ovr"}, overrun, 1'b0);
   endtask

   initial begin
      logic [3:0] ec;
      logic [3:0] pc;
      int n;
      kif.key_ready = 1'b1;
      model_reset();
      run(3);
      check_reset_values("reset");
      rst = 1'b0;

      // idle scan: each column for exactly SD samples
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) cycle();
         ec = 4'b0001 << ((k / SD) % 4);
         check("idle_col", col, ec);
      end

      // clean press of row 2 / col 1
      valid_seen = 0;
      pressed = 16'h0200;
      run(30);
      pressed = 16'h0000;
      run(20);
      check("press_count", valid_seen, 1);
      check("press_code", last_code, 9);

      // bounce timed onto the last dwell cycle of col 0010
      n = 0;
      pc = col;
      while (!(pc != 4'b0010 && col == 4'b0010) && n < 40) begin
         pc = col;
         cycle();
         n++;
      end
      check("bounce_align", n < 40, 1'b1);
      valid_seen = 0;
      raw_en = 1'b1;
      raw_row = 4'b0000;
      cycle();
      raw_row = 4'b0100;
      run(3);
      raw_row = 4'b0000;
      run(3);
      check("bounce_col", col, 4'b0100);
      run(5);
      raw_en = 1'b0;
      check("bounce_nokey", valid_seen, 0);

      // backpressure then overrun
      kif.key_ready = 1'b0;
      pressed = 16'h0001;
      run(40);
      pressed = 16'h0000;
      run(20);
      check("bp_code", kif.key_code, 4'd0);
      check("bp_valid", kif.key_valid, 1'b1);
      check("bp_ovr0", overrun, 1'b0);
      pressed = 16'h8000;
      run(40);
      pressed = 16'h0000;
      run(20);
      check("ovr_code", kif.key_code, 4'd0);
      check("ovr_valid", kif.key_valid, 1'b1);
      check("ovr_flag", overrun, 1'b1);
      kif.key_ready = 1'b1;
      cycle();
      check("pulse_valid", kif.key_valid, 1'b0);

      // two rows in column 0: lowest row wins
      valid_seen = 0;
      pressed = 16'h1010;
      run(40);
      pressed = 16'h0000;
      run(20);
      check("multi_count", valid_seen, 1);
      check("multi_code", last_code, 4);

      // randomized keys, noise and backpressure
      for (int s = 0; s < 60; s++) begin
         int len;
         int mode;
         len = $urandom_range(4, 50);
         mode = $urandom_range(0, 3);
         kif.key_ready = 1'($urandom_range(0, 1));
         raw_en = (mode == 3);
         pressed = (mode == 0) ? 16'h0000 : 16'h0001 << $urandom_range(0, 15);
         for (int c = 0; c < len; c++) begin
            if (mode == 3) raw_row = 4'($urandom);
            cycle();
         end
      end
      raw_en = 1'b0;
      pressed = 16'h0000;
      kif.key_ready = 1'b1;
      run(20);

      // asynchronous reset while a key is held
      pressed = 16'h0040;
      n = 0;
      while (key_down !== 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      check("hold_reached", key_down, 1'b1);
      #2 rst = 1'b1;
      #1 model_reset();
      check_reset_values("async_rst");
      run(2);
      rst = 1'b0;
      valid_seen = 0;
      run(40);
      check("redetect_count", valid_seen, 1);
      check("redetect_code", last_code, 6);
      pressed = 16'h0000;
      run(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
